// File: rtl/circle_raster_pkg.sv
// circle_raster_pkg
//   Shared types and width helpers for the midpoint circle rasteriser.
//   - state_e   : control FSM states (IDLE, EMIT, STEP, DONE)
//   - slot_t    : index of the symmetric point (0..7) emitted in one step
//   - cnt_width : width of the signed x/y step counters for a radius width
//   - d_width   : width of the signed decision variable for a radius width
package circle_raster_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_FIRST = 3'd0;
  localparam slot_t SLOT_LAST  = 3'd7;

  // x and y need two extra bits: one for sign, one for the y-1 / x+1 overshoot.
  function automatic int cnt_width(input int rw);
    return rw + 2;
  endfunction

  // d = 3-2r and its increments of 4(x-y)+10 need four extra bits.
  function automatic int d_width(input int rw);
    return rw + 4;
  endfunction

endpackage

// File: rtl/circle_raster_octant_map.sv
// octant_map
//   Combinational mapping of one symmetric slot to a screen pixel.
//   Inputs : slot_i (0..7), xc_i/yc_i centre, x_i/y_i signed step counters,
//            mask_i per-slot enable.
//   Outputs: px_o/py_o pixel coordinates (truncated to screen width),
//            live_o = slot enabled and pixel inside 0..SCR_W-1 x 0..SCR_H-1.
module octant_map
  import circle_raster_pkg::*;
#(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CNT_W = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic [2:0]              slot_i,
  input  logic [XW-1:0]           xc_i,
  input  logic [YW-1:0]           yc_i,
  input  logic signed [CNT_W-1:0] x_i,
  input  logic signed [CNT_W-1:0] y_i,
  input  logic [7:0]              mask_i,
  output logic [XW-1:0]           px_o,
  output logic [YW-1:0]           py_o,
  output logic                    live_o
);

  localparam logic signed [XW+1:0] SCR_W_S = (XW+2)'(SCR_W);
  localparam logic signed [YW+1:0] SCR_H_S = (YW+2)'(SCR_H);

  logic signed [XW+1:0] cx, ax, ay, px;
  logic signed [YW+1:0] cy, bx, by, py;

  always_comb begin
    cx = signed'({2'b00, xc_i});
    cy = signed'({2'b00, yc_i});
    // Sign-extend the counters into each axis' working width.
    ax = (XW+2)'(x_i);
    ay = (XW+2)'(y_i);
    bx = (YW+2)'(x_i);
    by = (YW+2)'(y_i);
    px = cx;
    py = cy;
    case (slot_t'(slot_i))
      3'd0:    begin px = cx + ax; py = cy + by; end
      3'd1:    begin px = cx - ax; py = cy + by; end
      3'd2:    begin px = cx + ax; py = cy - by; end
      3'd3:    begin px = cx - ax; py = cy - by; end
      3'd4:    begin px = cx + ay; py = cy + bx; end
      3'd5:    begin px = cx - ay; py = cy + bx; end
      3'd6:    begin px = cx + ay; py = cy - bx; end
      default: begin px = cx - ay; py = cy - bx; end
    endcase
    px_o   = px[XW-1:0];
    py_o   = py[YW-1:0];
    // Sign bit clear means >= 0; upper bound checked signed.
    live_o = mask_i[slot_i] && !px[XW+1] && (px < SCR_W_S)
                            && !py[YW+1] && (py < SCR_H_S);
  end

endmodule

// File: rtl/circle_raster.sv
// circle_raster
//   Midpoint circle rasteriser: one command (centre, radius, colour, slot
//   mask) becomes a stream of clipped pixel writes.
//   Ports: CLK50/RSTn clock and async active-low reset; start/xc/yc/r/
//   colour/oct_mask command (taken only when idle); busy/done status;
//   pix_valid/pix_ready/xo/yo/co pixel stream; dbg_state_o FSM state.
//   Handshake: a pixel transfers on a rising edge where pix_valid and
//   pix_ready are both 1; once raised, pix_valid and xo/yo/co hold until
//   that transfer happens.
module circle_raster
  import circle_raster_pkg::*;
#(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int RW    = 6,
  parameter int CW    = 3,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic          CLK50,
  input  logic          RSTn,
  input  logic          start,
  input  logic [XW-1:0] xc,
  input  logic [YW-1:0] yc,
  input  logic [RW-1:0] r,
  input  logic [CW-1:0] colour,
  input  logic [7:0]    oct_mask,
  output logic          busy,
  output logic          done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] xo,
  output logic [YW-1:0] yo,
  output logic [CW-1:0] co,
  output logic [1:0]    dbg_state_o
);

  localparam int CNT_W = cnt_width(RW);
  localparam int D_W   = d_width(RW);

  state_e                  state_q, state_d;
  slot_t                   slot_q, slot_d;
  logic signed [CNT_W-1:0] x_q, x_d, y_q, y_d, x_step, y_step;
  logic signed [D_W-1:0]   d_q, d_d, x_ext, y_ext;
  logic [XW-1:0]           xc_q, xc_d;
  logic [YW-1:0]           yc_q, yc_d;
  logic [CW-1:0]           col_q, col_d;
  logic [7:0]              mask_q, mask_d;
  logic                    pix_valid_q, pix_valid_d;
  logic [XW-1:0]           xo_q, map_px;
  logic [YW-1:0]           yo_q, map_py;
  logic [CW-1:0]           co_q;
  logic                    map_live;

  // The map looks at the next-cycle slot so the output register already
  // holds the pixel in the first EMIT cycle (slot 0 visible right after accept).
  octant_map #(
    .XW(XW), .YW(YW), .CNT_W(CNT_W), .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) u_map (
    .slot_i(slot_d), .xc_i(xc_d), .yc_i(yc_d), .x_i(x_d), .y_i(y_d),
    .mask_i(mask_d), .px_o(map_px), .py_o(map_py), .live_o(map_live)
  );

  // State register
  always_ff @(posedge CLK50 or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath next values
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    col_d   = col_q;
    mask_d  = mask_q;
    x_ext   = D_W'(x_q);
    y_ext   = D_W'(y_q);
    x_step  = x_q + CNT_W'(1);
    y_step  = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EMIT;
          slot_d  = SLOT_FIRST;
          x_d     = '0;
          y_d     = signed'({2'b00, r});
          d_d     = D_W'(3) - signed'({3'b000, r, 1'b0});
          xc_d    = xc;
          yc_d    = yc;
          col_d   = colour;
          mask_d  = oct_mask;
        end
      end
      S_EMIT: begin
        // Dead slots (valid low) advance unconditionally after one cycle.
        if (!pix_valid_q || pix_ready) begin
          if (slot_q == SLOT_LAST) state_d = S_STEP;
          else                     slot_d  = slot_q + 3'd1;
        end
      end
      S_STEP: begin
        if (d_q[D_W-1]) begin
          d_d = d_q + (x_ext <<< 2) + D_W'(6);
        end else begin
          d_d    = d_q + ((x_ext - y_ext) <<< 2) + D_W'(10);
          y_step = y_q - CNT_W'(1);
        end
        x_d = x_step;
        y_d = y_step;
        if (x_step > y_step) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EMIT;
          slot_d  = SLOT_FIRST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    dbg_state_o = state_q;
    pix_valid_d = (state_d == S_EMIT) && map_live;
    pix_valid   = pix_valid_q;
    xo          = xo_q;
    yo          = yo_q;
    co          = co_q;
  end

  // Datapath registers
  always_ff @(posedge CLK50 or negedge RSTn) begin
    if (!RSTn) begin
      slot_q <= SLOT_FIRST;
      x_q    <= '0;
      y_q    <= '0;
      d_q    <= '0;
      xc_q   <= '0;
      yc_q   <= '0;
      col_q  <= '0;
      mask_q <= '0;
    end else begin
      slot_q <= slot_d;
      x_q    <= x_d;
      y_q    <= y_d;
      d_q    <= d_d;
      xc_q   <= xc_d;
      yc_q   <= yc_d;
      col_q  <= col_d;
      mask_q <= mask_d;
    end
  end

  // Pixel output register
  always_ff @(posedge CLK50 or negedge RSTn) begin
    if (!RSTn) begin
      pix_valid_q <= 1'b0;
      xo_q        <= '0;
      yo_q        <= '0;
      co_q        <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;
      if (state_d == S_EMIT) begin
        xo_q <= map_px;
        yo_q <= map_py;
        co_q <= col_d;
      end
    end
  end

endmodule
